// File: rtl/bcd_lcg_if.sv
// Handshake/data bundle between a BCD LCG and its user.
// Latency: none, wires only.
// Backpressure: out_valid/out_ready pair; result is held until out_ready.
//
// Signals:
//   seed_load, seed  : seed request and packed BCD seed (digit 0 in [3:0])
//   step             : request to compute the next state
//   out_ready        : consumer accepts the presented value
//   value            : current generator state, packed BCD
//   out_valid, busy  : result presented / computation in progress
//   seed_err         : one-cycle pulse when a seed with a non-BCD digit is rejected
interface bcd_lcg_if #(
  parameter int DIGITS = 4
);
  logic                  seed_load;
  logic [4*DIGITS-1:0]   seed;
  logic                  step;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   value;
  logic                  out_valid;
  logic                  busy;
  logic                  seed_err;

  // master: the user driving requests and consuming results
  modport master (
    output seed_load, seed, step, out_ready,
    input  value, out_valid, busy, seed_err
  );

  // slave: the generator itself
  modport slave (
    input  seed_load, seed, step, out_ready,
    output value, out_valid, busy, seed_err
  );
endinterface

// File: rtl/bcd_lcg.sv
// Digit-serial BCD linear congruential generator: value <= (MULT*value + INC) mod 10^DIGITS.
// Latency: DIGITS cycles from accepted step to out_valid; one result per DIGITS+1 cycles when chained.
// Backpressure: result held in HOLD until out_ready; step during HOLD without out_ready is ignored.
//
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : asynchronous active-low reset (clears state, value and all flags)
//   bus    : bcd_lcg_if.slave (seed_load/seed/step/out_ready in; value/out_valid/busy/seed_err out)
module bcd_lcg #(
  parameter int DIGITS = 4,
  parameter int MULT   = 3,
  parameter int INC    = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  bcd_lcg_if.slave  bus
);

  // Reject illegal configurations at elaboration.
  generate
    if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
      $error("bcd_lcg: DIGITS must be in 1..16");
    end
    if (MULT < 1 || MULT > 9) begin : g_bad_mult
      $error("bcd_lcg: MULT must be in 1..9");
    end
    if (INC < 0 || INC > 9) begin : g_bad_inc
      $error("bcd_lcg: INC must be in 0..9");
    end
  endgenerate

  localparam int                IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0]   LAST  = IDXW'(DIGITS - 1);
  localparam logic [6:0]        MULT7 = 7'(MULT);
  localparam logic [6:0]        INC7  = 7'(INC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [3:0]            carry_q, carry_d;
  logic                  err_q, err_d;

  // Digit datapath signals
  logic [3:0]            cur_dig;
  logic [6:0]            prod;
  logic [3:0]            res_dig;
  logic [3:0]            res_carry;
  logic [4*DIGITS-1:0]   shadow_ins;
  logic                  seed_ok;

  // One digit of MULT*value + INC per cycle. prod peaks at 9*9+9 = 90,
  // so the carry into the next digit always fits in 4 bits.
  always_comb begin
    cur_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) cur_dig = value_q[4*i +: 4];
    end

    prod      = MULT7 * {3'b000, cur_dig}
              + {3'b000, carry_q}
              + ((idx_q == '0) ? INC7 : 7'd0);
    res_dig   = 4'(prod % 7'd10);
    res_carry = 4'(prod / 7'd10);

    // Partial results accumulate here so value stays stable until the last digit.
    shadow_ins = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) shadow_ins[4*i +: 4] = res_dig;
    end
  end

  // A seed is loadable only if every nibble is a valid BCD digit.
  always_comb begin
    seed_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.seed[4*i +: 4] > 4'd9) seed_ok = 1'b0;
    end
  end

  // Next-state and datapath-control logic.
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.seed_load) begin
          if (seed_ok) value_d = bus.seed;
          else         err_d   = 1'b1;
        end else if (bus.step) begin
          state_d = CALC;
          idx_d   = '0;
          carry_d = 4'd0;
        end
      end

      CALC: begin
        shadow_d = shadow_ins;
        if (idx_q == LAST) begin
          // Final carry is dropped: the modulus is 10^DIGITS.
          value_d = shadow_ins;
          state_d = HOLD;
          idx_d   = '0;
          carry_d = 4'd0;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          carry_d = res_carry;
        end
      end

      HOLD: begin
        // A seed request outranks consumption; a good seed discards the
        // unconsumed result, a bad one leaves it presented.
        if (bus.seed_load) begin
          if (seed_ok) begin
            value_d = bus.seed;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
          end
        end else if (bus.out_ready) begin
          if (bus.step) begin
            state_d = CALC;
            idx_d   = '0;
            carry_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      value_q  <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      carry_q  <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  assign bus.value     = value_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q == CALC);
  assign bus.seed_err  = err_q;

endmodule

// File: tb/tb_bcd_lcg.sv
// Self-checking bench for bcd_lcg (DIGITS=4, MULT=3, INC=7).
// Latency: n/a.
// Backpressure: bench drives out_ready directly, including stalls.
module tb_bcd_lcg;

  localparam int D    = 4;
  localparam int M    = 3;
  localparam int I    = 7;
  localparam int MOD  = 10000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   mv     = 0;   // reference state as a plain integer

  bcd_lcg_if #(.DIGITS(D)) bus ();

  bcd_lcg #(.DIGITS(D), .MULT(M), .INC(I)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] s);
    int r;
    int w;
    r = 0;
    w = 1;
    for (int k = 0; k < D; k++) begin
      r = r + int'(s[4*k +: 4]) * w;
      w = w * 10;
    end
    return r;
  endfunction

  function automatic bit is_bad(input logic [15:0] s);
    bit b;
    b = 1'b0;
    for (int k = 0; k < D; k++) if (s[4*k +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the first falling edge after the accepting edge.
  task automatic wait_valid(input string tag, input logic [15:0] held,
                            output int cyc, output int busy_cnt);
    bit held_ok;
    held_ok  = 1'b1;
    cyc      = 0;
    busy_cnt = 0;
    while (!bus.out_valid && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.value !== held) held_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "/value_held_in_calc"}, held_ok, 1);
    chk({tag, "/out_valid"}, bus.out_valid, 1);
  endtask

  // From IDLE: request one step and check latency, busy span and result.
  task automatic compute(input string tag);
    logic [15:0] old;
    int          cyc;
    int          bc;
    old = to_bcd(mv);
    bus.step      = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.step = 1'b0;
    wait_valid(tag, old, cyc, bc);
    mv = (M * mv + I) % MOD;
    chk({tag, "/latency"}, cyc, D);
    chk({tag, "/busy_cycles"}, bc, D);
    chk({tag, "/value"}, bus.value, to_bcd(mv));
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    bus.step      = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "/idle_valid"}, bus.out_valid, 0);
    chk({tag, "/idle_busy"}, bus.busy, 0);
  endtask

  // In HOLD: stall for n cycles with random step activity.
  task automatic stall(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      bus.out_ready = 1'b0;
      bus.step      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk({tag, "/stall_value"}, bus.value, to_bcd(mv));
      chk({tag, "/stall_valid"}, bus.out_valid, 1);
      chk({tag, "/stall_busy"}, bus.busy, 0);
    end
    bus.step = 1'b0;
  endtask

  // In HOLD: accept the result and start the next step on the same edge.
  task automatic chain(input string tag);
    logic [15:0] old;
    int          cyc;
    int          bc;
    old = to_bcd(mv);
    bus.out_ready = 1'b1;
    bus.step      = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.step      = 1'b0;
    chk({tag, "/no_idle_gap"}, bus.busy, 1);
    wait_valid(tag, old, cyc, bc);
    mv = (M * mv + I) % MOD;
    chk({tag, "/period"}, cyc + 1, D + 1);
    chk({tag, "/value"}, bus.value, to_bcd(mv));
  endtask

  // Seed request; in_hold says whether the generator presents a result now.
  task automatic load_seed(input string tag, input logic [15:0] s, input bit in_hold);
    bit bad;
    bad = is_bad(s);
    bus.seed      = s;
    bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.step      = 1'b0;
    bus.out_ready = 1'b0;
    if (!bad) mv = from_bcd(s);
    chk({tag, "/seed_err"}, bus.seed_err, bad);
    chk({tag, "/value"}, bus.value, to_bcd(mv));
    chk({tag, "/out_valid"}, bus.out_valid, bad ? in_hold : 1'b0);
    chk({tag, "/busy"}, bus.busy, 0);
    @(negedge clk);
    chk({tag, "/seed_err_gone"}, bus.seed_err, 0);
  endtask

  initial begin
    logic [15:0] seq [8];
    logic [15:0] s;
    int          cyc;
    int          bc;
    int          n;
    seq = '{16'h0007, 16'h0028, 16'h0091, 16'h0280,
            16'h0847, 16'h2548, 16'h7651, 16'h2960};

    bus.seed_load = 1'b0;
    bus.seed      = '0;
    bus.step      = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset/value", bus.value, 16'h0000);
    chk("reset/out_valid", bus.out_valid, 0);
    chk("reset/busy", bus.busy, 0);
    chk("reset/seed_err", bus.seed_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release accepts a step; known sequence from 0.
    mv = 0;
    for (int k = 0; k < 8; k++) begin
      compute("seq");
      chk("seq/table", bus.value, seq[k]);
      consume("seq");
    end

    // Wrap-around: 3*9999+7 = 30004 -> 0004.
    load_seed("seed9999", 16'h9999, 1'b0);
    compute("wrap");
    chk("wrap/table", bus.value, 16'h0004);
    consume("wrap");

    // Illegal seed keeps old value; next step uses it (3*4+7 = 19).
    load_seed("bad_seed", 16'h12A4, 1'b0);
    compute("after_bad");
    chk("after_bad/table", bus.value, 16'h0019);
    consume("after_bad");

    // Backpressure in HOLD.
    compute("stall");
    stall("stall", 10);
    consume("stall");

    // Back-to-back chained steps.
    compute("chain0");
    chain("chain1");
    chain("chain2");
    chain("chain3");
    consume("chain");

    // Seed with out_ready+step in HOLD is a seed load, not a chain.
    compute("hold_seed");
    bus.out_ready = 1'b1;
    bus.step      = 1'b1;
    load_seed("hold_seed", 16'h0123, 1'b1);
    chk("hold_seed/not_chained", bus.busy, 0);

    // Bad seed in HOLD leaves the result presented.
    compute("hold_bad");
    load_seed("hold_bad", 16'hF000, 1'b1);
    consume("hold_bad");

    // Seed request during CALC is ignored.
    s = to_bcd(mv);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step      = 1'b0;
    bus.seed      = 16'h5555;
    bus.seed_load = 1'b1;
    @(negedge clk);
    bus.seed_load = 1'b0;
    chk("calc_seed/busy", bus.busy, 1);
    chk("calc_seed/no_err", bus.seed_err, 0);
    wait_valid("calc_seed", s, cyc, bc);
    mv = (M * mv + I) % MOD;
    chk("calc_seed/value", bus.value, to_bcd(mv));
    consume("calc_seed");

    // Asynchronous reset while digit 2 is being computed.
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset/busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset/value", bus.value, 16'h0000);
    chk("midreset/busy", bus.busy, 0);
    chk("midreset/out_valid", bus.out_valid, 0);
    chk("midreset/seed_err", bus.seed_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mv = 0;
    compute("midreset_next");
    chk("midreset_next/table", bus.value, 16'h0007);
    consume("midreset_next");

    // Randomized seeds, steps and stalls.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < D; k++) s[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) s[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      load_seed("rnd_seed", s, 1'b0);
      n = $urandom_range(1, 3);
      compute("rnd");
      for (int k = 1; k < n; k++) begin
        stall("rnd", $urandom_range(0, 3));
        chain("rnd_chain");
      end
      stall("rnd", $urandom_range(0, 2));
      consume("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
